// File: rtl/vc_drop_unit.sv
// Purpose: discards the next N response beats owed to squashed requests, passing survivors unchanged.
// Latency: zero-cycle combinational pass-through; the drop count updates on the rising clock edge.
// Backpressure: passes out_rdy to in_rdy while forwarding; always ready while discarding.
module vc_drop_unit #(
  parameter int p_msg_nbits = 32,
  parameter int p_max_drops = 4   // legal range 1..15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   drop,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_val,
  output logic                   in_rdy,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic                   drop_pending,
  output logic                   overflow
);

  localparam int CW = $clog2(p_max_drops + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(p_max_drops);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Number of responses still owed a discard. The PASS/DROP state is
  // derived from this count (DROP whenever it is non-zero), so no separate
  // state register exists that could disagree with it.
  logic [CW-1:0] cnt;
  logic          overflow_q;

  logic in_drop_state;  // DROP state: at least one registered drop owed
  logic discarding;     // this cycle's beat, if any, is thrown away
  logic discard;        // a beat is actually consumed and discarded

  // A same-cycle drop pulse already claims the beat arriving with it, so
  // discarding is active in DROP or whenever drop is high. Reset forces the
  // plain PASS behaviour on the outputs regardless of drop.
  always_comb begin
    in_drop_state = (cnt != '0);
    discarding    = !reset && (in_drop_state || drop);
    discard       = discarding && in_val;
  end

  // Output steering: only the valid and ready handshake is gated, the
  // message bus is a straight wire.
  always_comb begin
    out_msg      = in_msg;
    out_val      = in_val && !discarding;
    in_rdy       = discarding ? 1'b1 : out_rdy;
    drop_pending = in_drop_state || drop;
    overflow     = overflow_q;
  end

  // Drop counter: next = cnt + drop - discard, saturating at the maximum
  // (which raises the sticky overflow flag) and never wrapping below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop && !discard) begin
        if (cnt == CNT_MAX) begin
          overflow_q <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (!drop && discard && in_drop_state) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: doc/vc_drop_unit.md
VC_DROP_UNIT -- requirements
Module: vc_drop_unit

Interface
REQ-001 SHALL have parameter p_msg_nbits, default 32, message width in bits.
REQ-002 SHALL have parameter p_max_drops, default 4, maximum outstanding drops, which SHALL be between 1 and 15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port drop  input  1  one-cycle pulse per in-flight response to discard; driven from a stage's prev_squash.
REQ-006 SHALL have port in_msg  input  p_msg_nbits  response message from memory/upstream.
REQ-007 SHALL have port in_val  input  1  in_msg valid.
REQ-008 SHALL have port in_rdy  output  1  unit accepts in_msg.
REQ-009 SHALL have port out_msg  output  p_msg_nbits  surviving response to the consuming pipeline stage.
REQ-010 SHALL have port out_val  output  1  out_msg valid.
REQ-011 SHALL have port out_rdy  input  1  consumer accepts out_msg.
REQ-012 SHALL have port drop_pending  output  1  high while at least one drop is owed.
REQ-013 SHALL have port overflow  output  1  sticky error flag: a drop arrived with the counter full.

Function
REQ-014 SHALL hold a drop counter cnt, $clog2(p_max_drops+1) bits wide, counting owed discards.
REQ-015 SHALL implement a two-state FSM: PASS (cnt==0) and DROP (cnt>0), with the state derived from cnt.
REQ-016 In PASS with drop=0, the unit SHALL be zero-latency combinational pass-through: out_val=in_val, out_msg=in_msg, in_rdy=out_rdy.
REQ-017 In DROP, or in PASS with drop=1, the unit SHALL set in_rdy=1 and out_val=0, so any in_val beat that cycle is consumed and discarded.
REQ-018 A discard is a cycle with in_val && in_rdy while discarding; it SHALL consume one owed drop, either the registered count or the same-cycle drop.
REQ-019 Next cnt SHALL equal cnt + drop - discard: simultaneous drop and discard leaves cnt unchanged, and drop with no discard increments cnt.
REQ-020 The PASS to DROP transition SHALL occur when drop=1 and no beat is discarded that cycle.
REQ-021 The DROP to PASS transition SHALL occur when cnt==1, a beat is discarded, and drop=0.
REQ-022 When cnt==p_max_drops, drop=1 and no discard occurs, cnt SHALL saturate and overflow SHALL set, remaining 1 until reset.
REQ-023 When cnt==0, drop=0 and a discard occurs, cnt SHALL not underflow.
REQ-024 drop_pending SHALL equal (cnt!=0) || drop.
REQ-025 out_msg SHALL equal in_msg at all times; only out_val is gated.

Reset
REQ-026 On reset assertion, cnt and overflow SHALL clear to 0 immediately (asynchronous), independent of clk.
REQ-027 While reset is high, outputs SHALL be in_rdy=out_rdy, out_val=in_val, drop_pending=drop and overflow=0 (PASS behaviour).
REQ-028 Reset asserted mid-DROP SHALL abandon owed drops; the first beat after reset SHALL pass through.

Structure
REQ-029 The module SHALL be single-file RTL with no package; it SHALL have no typedefs, and cnt width SHALL be a local parameter.
REQ-030 cnt SHALL be held in a single register; a separate sub-module is not required.
REQ-031 The module SHALL have no combinational path from drop to any stage other than this unit's in_rdy/out_val.

Verification
REQ-032 After reset, with out_rdy=1 and in_val=1, in_msg=0x11 for 3 cycles, the bench SHALL see out_val=1 with 0x11 each cycle, and cnt SHALL stay 0.
REQ-033 With drop pulsed once and no in_val, followed 2 cycles later by beats 0xA0 and 0xA1, the bench SHALL see 0xA0 discarded (in_rdy=1, out_val=0) and 0xA1 delivered.
REQ-034 With drop=1 and in_val=1, in_msg=0x55 in the same cycle from PASS, the bench SHALL see 0x55 discarded and cnt remain 0.
REQ-035 With 3 drop pulses, then drop=1 coinciding with a discarded beat, the bench SHALL see cnt hold at 3, and exactly 3 further beats discarded.
REQ-036 With p_max_drops=4 and 5 drop pulses with no beats, the bench SHALL see cnt=4 and overflow=1, and overflow SHALL remain 1 until reset.
REQ-037 With cnt=2 and reset asserted asynchronously between clock edges, the bench SHALL see cnt=0 immediately, and the next beat 0x77 SHALL pass through.
